// File: rtl/rv32i_types.sv
// Shared RVFI record types: the committed rvfi_t, its dispatch-time static half,
// its writeback-time dynamic half, and rvfi_merge() which joins them at commit.
package rv32i_types;

  localparam int RVFI_ORDER_W = 64;

  typedef struct packed {
    logic                    valid;
    logic [RVFI_ORDER_W-1:0] order;
    logic [31:0]             inst;
    logic                    trap;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [31:0]             rs1_rdata;
    logic [31:0]             rs2_rdata;
    logic [4:0]              rd_addr;
    logic [31:0]             rd_wdata;
    logic [31:0]             pc_rdata;
    logic [31:0]             pc_wdata;
    logic [31:0]             mem_addr;
    logic [3:0]              mem_rmask;
    logic [3:0]              mem_wmask;
    logic [31:0]             mem_rdata;
    logic [31:0]             mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } rvfi_alloc_t;

  typedef struct packed {
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        trap;
  } rvfi_wb_t;

  function automatic rvfi_t rvfi_merge(input rvfi_alloc_t a, input rvfi_wb_t w,
                                       input logic [RVFI_ORDER_W-1:0] order);
    rvfi_t r;
    r           = '0;
    r.valid     = 1'b1;
    r.order     = order;
    r.inst      = a.inst;
    r.pc_rdata  = a.pc_rdata;
    r.rs1_addr  = a.rs1_addr;
    r.rs2_addr  = a.rs2_addr;
    r.rd_addr   = a.rd_addr;
    r.rs1_rdata = w.rs1_rdata;
    r.rs2_rdata = w.rs2_rdata;
    r.rd_wdata  = w.rd_wdata;
    r.pc_wdata  = w.pc_wdata;
    r.mem_addr  = w.mem_addr;
    r.mem_rmask = w.mem_rmask;
    r.mem_wmask = w.mem_wmask;
    r.mem_rdata = w.mem_rdata;
    r.mem_wdata = w.mem_wdata;
    r.trap      = w.trap;
    return r;
  endfunction

endpackage

// File: rtl/rvfi_commit_buffer_wb_merge.sv
// Per-entry writeback decode: which entries are written this cycle and with which
// port's data. Ports are scanned low to high so the highest-numbered port wins.
module rvfi_wb_merge
  import rv32i_types::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int NUM_WB = 2,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic [NUM_WB-1:0]            wb_valid_i,
  input  logic [NUM_WB-1:0][IDX_W-1:0] wb_idx_i,
  input  rvfi_wb_t [NUM_WB-1:0]        wb_data_i,
  output logic [DEPTH-1:0]             we_o,
  output rvfi_wb_t [DEPTH-1:0]         wdata_o
);

  always_comb begin
    we_o    = '0;
    wdata_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && (wb_idx_i[p] == IDX_W'(e))) begin
          we_o[e]    = 1'b1;
          wdata_o[e] = wb_data_i[p];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_buffer.sv
// RVFI record buffer beside the ROB: alloc -> writeback -> in-order commit with a
// registered, order-stamped output. Define RVFI_ERR_EN to add the sticky err_o checker.
module rvfi_commit_buffer
  import rv32i_types::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int NUM_WB = 2,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid_i,
  input  logic [IDX_W-1:0]             alloc_idx_i,
  input  rvfi_alloc_t                  alloc_data_i,
  input  logic [NUM_WB-1:0]            wb_valid_i,
  input  logic [NUM_WB-1:0][IDX_W-1:0] wb_idx_i,
  input  rvfi_wb_t [NUM_WB-1:0]        wb_data_i,
  input  logic                         commit_valid_i,
  input  logic [IDX_W-1:0]             commit_idx_i,
  input  logic                         flush_i,
  output rvfi_t                        rvfi_out_o,
  output logic                         rvfi_out_valid_o,
  output logic [CNT_W-1:0]             count_o
`ifdef RVFI_ERR_EN
  ,
  output logic                         err_o
`endif
);

  rvfi_alloc_t [DEPTH-1:0]   st_q, st_d;
  rvfi_wb_t [DEPTH-1:0]      dyn_q, dyn_d;
  logic [RVFI_ORDER_W-1:0]   order_q, order_d;
  logic [CNT_W-1:0]          count_q, count_d;
  rvfi_t                     out_q, out_d;
  logic                      out_valid_q, out_valid_d;

  logic [DEPTH-1:0]          wb_we;
  rvfi_wb_t [DEPTH-1:0]      wb_wdata;
  rvfi_wb_t                  commit_dyn;

  rvfi_wb_merge #(
    .DEPTH (DEPTH),
    .NUM_WB(NUM_WB)
  ) u_wb_merge (
    .wb_valid_i(wb_valid_i),
    .wb_idx_i  (wb_idx_i),
    .wb_data_i (wb_data_i),
    .we_o      (wb_we),
    .wdata_o   (wb_wdata)
  );

  // Same-cycle writeback to the retiring entry is forwarded straight into the record.
  assign commit_dyn = wb_we[commit_idx_i] ? wb_wdata[commit_idx_i] : dyn_q[commit_idx_i];

  always_comb begin
    st_d        = st_q;
    dyn_d       = dyn_q;
    order_d     = order_q;
    count_d     = count_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    if (flush_i) begin
      count_d = '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_we[e]) dyn_d[e] = wb_wdata[e];
      end
      if (commit_valid_i) begin
        out_d       = rvfi_merge(st_q[commit_idx_i], commit_dyn, order_q);
        out_valid_d = 1'b1;
        order_d     = order_q + RVFI_ORDER_W'(1);
      end
      // Alloc is applied last so it overrides a writeback to the same entry.
      if (alloc_valid_i) begin
        st_d[alloc_idx_i]  = alloc_data_i;
        dyn_d[alloc_idx_i] = '0;
      end
      if (alloc_valid_i && !commit_valid_i) begin
        if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
      end else if (!alloc_valid_i && commit_valid_i) begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= '0;
      dyn_q       <= '0;
      order_q     <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      dyn_q       <= dyn_d;
      order_q     <= order_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rvfi_out_o       = out_q;
  assign rvfi_out_valid_o = out_valid_q;
  assign count_o          = count_q;

`ifdef RVFI_ERR_EN
  // Allocated/done bits are only observed by the protocol checker.
  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic             err_q, err_set;

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    err_set = 1'b0;
    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
    end else begin
      done_d = done_q | wb_we;
      if (commit_valid_i) begin
        alloc_d[commit_idx_i] = 1'b0;
        done_d[commit_idx_i]  = 1'b0;
      end
      if (alloc_valid_i) begin
        alloc_d[alloc_idx_i] = 1'b1;
        done_d[alloc_idx_i]  = 1'b0;
      end
      if ((wb_we & ~alloc_q) != '0) err_set = 1'b1;
      if (commit_valid_i && !done_q[commit_idx_i] && !wb_we[commit_idx_i]) err_set = 1'b1;
      if (alloc_valid_i && alloc_q[alloc_idx_i] &&
          !(commit_valid_i && (commit_idx_i == alloc_idx_i))) err_set = 1'b1;
      if (alloc_valid_i && !commit_valid_i && (count_q == CNT_W'(DEPTH))) err_set = 1'b1;
      if (!alloc_valid_i && commit_valid_i && (count_q == '0)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Bench for rvfi_commit_buffer: directed scenarios then random traffic, all checked by
// a scoreboard fed from a per-entry reference model of the record buffer.
module tb_rvfi_commit_buffer;
  import rv32i_types::*;

  localparam int DEPTH  = 16;
  localparam int NUM_WB = 2;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int W      = $bits(rvfi_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                         alloc_valid = 1'b0;
  logic [IDX_W-1:0]             alloc_idx = '0;
  rvfi_alloc_t                  alloc_data = '0;
  logic [NUM_WB-1:0]            wb_valid = '0;
  logic [NUM_WB-1:0][IDX_W-1:0] wb_idx = '0;
  rvfi_wb_t [NUM_WB-1:0]        wb_data = '0;
  logic                         commit_valid = 1'b0;
  logic [IDX_W-1:0]             commit_idx = '0;
  logic                         flush = 1'b0;
  rvfi_t                        rvfi_out;
  logic                         rvfi_out_valid;
  logic [CNT_W-1:0]             count;
`ifdef RVFI_ERR_EN
  logic                         err;
`endif

  rvfi_commit_buffer #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid_i   (alloc_valid),
    .alloc_idx_i     (alloc_idx),
    .alloc_data_i    (alloc_data),
    .wb_valid_i      (wb_valid),
    .wb_idx_i        (wb_idx),
    .wb_data_i       (wb_data),
    .commit_valid_i  (commit_valid),
    .commit_idx_i    (commit_idx),
    .flush_i         (flush),
    .rvfi_out_o      (rvfi_out),
    .rvfi_out_valid_o(rvfi_out_valid),
    .count_o         (count)
`ifdef RVFI_ERR_EN
    ,
    .err_o           (err)
`endif
  );

  // reference model and scoreboard
  rvfi_alloc_t   m_st[DEPTH];
  rvfi_wb_t      m_dyn[DEPTH];
  int            m_count = 0;
  logic [63:0]   m_order = '0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;
  rvfi_t         last_out = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_rec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic rvfi_t expect_rec(input rvfi_alloc_t a, input rvfi_wb_t w,
                                       input logic [63:0] ord);
    rvfi_t r;
    r = '0;
    r.valid = 1'b1;      r.order = ord;          r.inst = a.inst;
    r.pc_rdata = a.pc_rdata;  r.rs1_addr = a.rs1_addr;  r.rs2_addr = a.rs2_addr;
    r.rd_addr = a.rd_addr;    r.rs1_rdata = w.rs1_rdata; r.rs2_rdata = w.rs2_rdata;
    r.rd_wdata = w.rd_wdata;  r.pc_wdata = w.pc_wdata;   r.mem_addr = w.mem_addr;
    r.mem_rmask = w.mem_rmask; r.mem_wmask = w.mem_wmask; r.mem_rdata = w.mem_rdata;
    r.mem_wdata = w.mem_wdata; r.trap = w.trap;
    return r;
  endfunction

  task automatic model_step();
    rvfi_wb_t d;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_st[i]  = '0;
        m_dyn[i] = '0;
      end
      m_count = 0;
      m_order = '0;
      exp_q.delete();
    end else if (flush) begin
      m_count = 0;
    end else begin
      if (commit_valid) begin
        d = m_dyn[commit_idx];
        for (int p = 0; p < NUM_WB; p++)
          if (wb_valid[p] && wb_idx[p] == commit_idx) d = wb_data[p];
        exp_q.push_back(expect_rec(m_st[commit_idx], d, m_order));
        m_order = m_order + 64'd1;
      end
      for (int p = 0; p < NUM_WB; p++)
        if (wb_valid[p]) m_dyn[wb_idx[p]] = wb_data[p];
      if (alloc_valid) begin
        m_st[alloc_idx]  = alloc_data;
        m_dyn[alloc_idx] = '0;
      end
      m_count = m_count + (alloc_valid ? 1 : 0) - (commit_valid ? 1 : 0);
      if (m_count > DEPTH) m_count = DEPTH;
      if (m_count < 0) m_count = 0;
    end
  endtask

  // monitor: one output expected exactly one cycle after each modelled commit
  always @(negedge clk) begin
    if (rvfi_out_valid) begin
      last_out = rvfi_out;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got %h with nothing expected", rvfi_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk_rec("commit_record", rvfi_out, mon_exp);
      end
    end else begin
      chk_rec("idle_out_zero", rvfi_out, '0);
      if (exp_q.size() != 0) begin
        chk("missing_out", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
    end
    chk("count", 64'(count), 64'(m_count));
  end

  // driver tasks
  task automatic idle();
    alloc_valid = 1'b0; wb_valid = '0; commit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    idle();
  endtask

  function automatic rvfi_alloc_t rnd_alloc();
    rvfi_alloc_t a;
    a.inst = $urandom; a.pc_rdata = $urandom;
    a.rs1_addr = 5'($urandom); a.rs2_addr = 5'($urandom); a.rd_addr = 5'($urandom);
    return a;
  endfunction

  function automatic rvfi_wb_t rnd_wb();
    rvfi_wb_t w;
    w.rs1_rdata = $urandom; w.rs2_rdata = $urandom; w.rd_wdata = $urandom;
    w.pc_wdata = $urandom;  w.mem_addr = $urandom;  w.mem_rmask = 4'($urandom);
    w.mem_wmask = 4'($urandom); w.mem_rdata = $urandom; w.mem_wdata = $urandom;
    w.trap = 1'($urandom);
    return w;
  endfunction

  task automatic set_alloc(input int idx, input logic [31:0] pc);
    alloc_valid = 1'b1; alloc_idx = IDX_W'(idx);
    alloc_data = rnd_alloc(); alloc_data.pc_rdata = pc;
  endtask

  task automatic set_wb(input int port, input int idx, input logic [31:0] rd);
    wb_valid[port] = 1'b1; wb_idx[port] = IDX_W'(idx);
    wb_data[port] = rnd_wb(); wb_data[port].rd_wdata = rd;
  endtask

  task automatic set_commit(input int idx);
    commit_valid = 1'b1; commit_idx = IDX_W'(idx);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    do_cycle(); do_cycle();
    rst = 1'b0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(rvfi_out_valid), 64'd0);
`ifdef RVFI_ERR_EN
    chk("reset_err", 64'(err), 64'd0);
`endif

    // basic alloc / wb / commit
    set_alloc(3, 32'h6000_0000); do_cycle();
    chk("t1_count_alloc", 64'(count), 64'd1);
    set_wb(0, 3, 32'h5); do_cycle();
    set_commit(3); do_cycle();
    chk("t1_valid", 64'(last_out.valid), 64'd1);
    chk("t1_order", last_out.order, 64'd0);
    chk("t1_pc", 64'(last_out.pc_rdata), 64'h6000_0000);
    chk("t1_rd", 64'(last_out.rd_wdata), 64'h5);
    chk("t1_count_commit", 64'(count), 64'd0);

    // two ports, same index: highest port wins
    set_alloc(2, 32'h6000_0010); do_cycle();
    set_wb(0, 2, 32'hAA); set_wb(1, 2, 32'hBB); do_cycle();
    set_commit(2); do_cycle();
    chk("t2_rd", 64'(last_out.rd_wdata), 64'hBB);
    chk("t2_order", last_out.order, 64'd1);

    // full wrap: commit and alloc of entry 0 in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(i, (i == 0) ? 32'h6100_0000 : 32'h6100_0000 + 32'(i * 4)); do_cycle();
    end
    chk("t3_full", 64'(count), 64'd16);
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_wb(0, 2 * i, 32'h1000 + 32'(2 * i)); set_wb(1, 2 * i + 1, 32'h1000 + 32'(2 * i + 1));
      do_cycle();
    end
    set_commit(0); set_alloc(0, 32'h7000_0000); do_cycle();
    chk("t3_old_pc", 64'(last_out.pc_rdata), 64'h6100_0000);
    chk("t3_old_rd", 64'(last_out.rd_wdata), 64'h1000);
    chk("t3_count_held", 64'(count), 64'd16);
    set_wb(0, 0, 32'h222); do_cycle();
    set_commit(0); do_cycle();
    chk("t3_new_pc", 64'(last_out.pc_rdata), 64'h7000_0000);
    chk("t3_new_rd", 64'(last_out.rd_wdata), 64'h222);
    chk("t3_count_after", 64'(count), 64'd15);

    // mid-operation reset, back-to-back commits, flush keeps order
    rst = 1'b1; do_cycle(); rst = 1'b0;
    chk("t4_reset_count", 64'(count), 64'd0);
    set_alloc(0, 32'h100); do_cycle();
    set_alloc(1, 32'h104); set_wb(0, 0, 32'h10); do_cycle();
    set_alloc(2, 32'h108); set_wb(0, 1, 32'h11); do_cycle();
    set_wb(1, 2, 32'h12); do_cycle();
    set_commit(0); do_cycle();
    chk("t4_order0", last_out.order, 64'd0);
    set_commit(1); do_cycle();
    chk("t4_order1", last_out.order, 64'd1);
    set_commit(2); do_cycle();
    chk("t4_order2", last_out.order, 64'd2);
    set_alloc(7, 32'h200); do_cycle();
    set_alloc(8, 32'h204); do_cycle();
    chk("t4_count_pre_flush", 64'(count), 64'd2);
    flush = 1'b1; set_commit(7); set_alloc(9, 32'h208); set_wb(0, 8, 32'h99); do_cycle();
    chk("t4_flush_count", 64'(count), 64'd0);
    chk("t4_flush_no_out", 64'(rvfi_out_valid), 64'd0);
    set_alloc(4, 32'h300); do_cycle();
    set_wb(1, 4, 32'h44); do_cycle();
    set_commit(4); do_cycle();
    chk("t4_order3", last_out.order, 64'd3);
    chk("t4_rd", 64'(last_out.rd_wdata), 64'h44);

    // zero-cycle writeback bypass into the commit
    set_alloc(5, 32'h400); do_cycle();
    set_commit(5); set_wb(1, 5, 32'h77); do_cycle();
    chk("t5_bypass_rd", 64'(last_out.rd_wdata), 64'h77);
    chk("t5_bypass_pc", 64'(last_out.pc_rdata), 64'h400);
`ifdef RVFI_ERR_EN
    chk("t5_err_clear", 64'(err), 64'd0);
    set_wb(0, 9, 32'h1); do_cycle();
    chk("t6_err_set", 64'(err), 64'd1);
    do_cycle(); do_cycle(); do_cycle();
    chk("t6_err_sticky", 64'(err), 64'd1);
    rst = 1'b1; do_cycle(); rst = 1'b0;
    chk("t6_err_reset", 64'(err), 64'd0);
`endif

    // random traffic, including illegal sequences and flushes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1) set_alloc($urandom_range(0, DEPTH - 1), $urandom);
      for (int p = 0; p < NUM_WB; p++)
        if ($urandom_range(0, 1) == 1) set_wb(p, $urandom_range(0, DEPTH - 1), $urandom);
      if ($urandom_range(0, 2) != 0) set_commit($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 31) == 0) flush = 1'b1;
      do_cycle();
    end

    do_cycle(); do_cycle();
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_buffer.md
# rvfi_commit_buffer

Parametrised successor of the single-port RVFI array. It sits beside the ROB and holds one RVFI record per ROB entry. The record is built in three stages: a dispatch allocation, up to NUM_WB writeback ports, and an in-order commit. At commit it emits a registered, order-stamped `rvfi_t` to the formal-interface monitor. It also tracks per-entry valid/done state, occupancy, pipeline flush and optional protocol error detection.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥ 2; `IDX_W = $clog2(DEPTH)`.
- `NUM_WB`, 2: number of writeback ports, 1..4.
- `clk` input 1: clock, all state updates on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `alloc_valid` input 1: allocate entry `alloc_idx` this cycle.
- `alloc_idx` input IDX_W: ROB index being allocated.
- `alloc_data` input `rvfi_alloc_t`: static fields (inst, pc_rdata, rs1/rs2/rd addr).
- `wb_valid` input [NUM_WB]: per-port writeback strobe.
- `wb_idx` input [NUM_WB][IDX_W]: per-port target index.
- `wb_data` input [NUM_WB] `rvfi_wb_t`: dynamic fields (rs1/rs2_rdata, rd_wdata, pc_wdata, mem addr/masks/data, trap).
- `commit_valid` input 1: ROB retires `commit_idx`.
- `commit_idx` input IDX_W: retiring index.
- `flush` input 1: discard all in-flight entries.
- `rvfi_out` output `rvfi_t`: committed record.
- `rvfi_out_valid` output 1: `rvfi_out` valid this cycle.
- `count` output $clog2(DEPTH+1): allocated entries.
- `err` output 1: present only with `RVFI_ERR_EN`; sticky protocol error.

## Operation
- Per-entry state: `alloc_bit`, `done_bit`, static struct, dynamic struct.
- **Alloc**
  - Writes the static struct.
  - Sets `alloc_bit`, clears `done_bit`.
  - Dynamic struct is cleared to 0.
- **Writeback**
  - Each port writes the dynamic struct of `wb_idx[p]` and sets `done_bit`.
  - Two ports on the same index in one cycle: highest port number wins.
- **Commit**
  - Output record = static ∪ dynamic fields of `commit_idx`, `order` = internal 64-bit counter, `valid` = 1.
  - The entry's `alloc_bit` and `done_bit` are cleared.
  - The order counter increments by 1 and wraps at 2^64.
- **Same-cycle events**
  - Writeback and commit to the same index: the writeback data is bypassed into `rvfi_out`.
  - Alloc and commit to the same index (full wrap): commit reads the old contents; alloc installs the new entry.
  - Alloc and writeback to the same index: alloc wins, `done_bit` = 0.
- **Count**
  - `count` = count + alloc − commit, saturating at 0 and DEPTH.
- **Flush**
  - Clears all `alloc_bit`/`done_bit` and `count`.
  - Flush takes priority over alloc, writeback and commit presented in the same cycle; those inputs are ignored.
  - A commit presented with `flush` produces no output.
  - The order counter is retained.
- **Reset**
  - All state, `count`, the order counter, `rvfi_out`, `rvfi_out_valid` and `err` go to 0.
  - Reset mid-operation discards everything; there is no partial-state retention.

## Timing
- Alloc and writeback are visible to a commit issued in the following cycle.
- Writeback to the commit index in the commit cycle is bypassed (0-cycle).
- Commit latency is 1 cycle: inputs at edge N give `rvfi_out`/`rvfi_out_valid` after edge N+1. Both are registered.
- `rvfi_out_valid` is a 1-cycle pulse per commit. `rvfi_out` is 0 whenever valid is 0.
- Back-to-back commits every cycle are supported, giving consecutive orders.
- `count` is registered and updates on the edge after the event.

## Configuration
- `RVFI_ERR_EN` defined: `err` port exists. It is set (sticky until `rst`) on any of:
  - writeback to an entry with `alloc_bit` = 0;
  - commit of an entry with `done_bit` = 0, bypass counted;
  - alloc of an entry with `alloc_bit` = 1 and no same-cycle commit;
  - `count` overflow or underflow.
  - `err` rises 1 cycle after the offending edge.
- `RVFI_ERR_EN` undefined: no `err` port and no checking logic. Illegal sequences still follow the priority rules above.

## Structure
- `rvfi_alloc_t`, `rvfi_wb_t` and a `rvfi_merge` function (builds `rvfi_t` from both structs) belong in `rv32i_types` next to `rvfi_t`.
- Sub-module `rvfi_wb_merge`: combinational N-port writeback priority/decode per entry, producing the write-enable vector and the selected data.

## Test plan
- After reset, alloc idx 3 (pc 0x60000000), wb port 0 idx 3 (rd_wdata 0x5), commit idx 3 → next cycle `rvfi_out_valid` = 1, order 0, pc_rdata 0x60000000, rd_wdata 0x5; `count` 1→0.
- wb port 0 and port 1 both to idx 2 (0xAA / 0xBB), then commit idx 2 → rd_wdata 0xBB.
- Fill all 16 entries, then commit idx 0 and alloc idx 0 in the same cycle → output carries the old entry-0 data; the next commit of idx 0 carries the new data; `count` stays 16.
- Three commits in consecutive cycles → orders 0, 1, 2 on consecutive cycles. Flush, then one more alloc/wb/commit → order 3, `count` 0 immediately after the flush.
- Commit idx 5 with a same-cycle wb to idx 5 (rd_wdata 0x77) → output rd_wdata 0x77; with `RVFI_ERR_EN`, `err` stays 0.
- With `RVFI_ERR_EN`: wb to unallocated idx 9 → `err` = 1 the next cycle and stays 1 until `rst`.
